reorder_buffer: RTL and testbench



---
 rtl/reorder_buffer_if.sv | 38 +++
 rtl/reorder_buffer.sv | 136 +++++++++++++
 tb/tb_reorder_buffer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// Rename/completion/commit bundle of the reorder buffer: dispatch and completion in, tags and retire out.
interface reorder_buffer_if #(
  parameter int DEPTH  = 16,
  parameter int PREG_W = 6,
  parameter int IDX_W  = $clog2(DEPTH)
);
  logic              disp_valid_1, disp_valid_2;
  logic [4:0]        disp_rd_1, disp_rd_2;
  logic [PREG_W-1:0] disp_prd_1, disp_prd_2;
  logic [PREG_W-1:0] disp_old_prd_1, disp_old_prd_2;
  logic              disp_reg_write_1, disp_reg_write_2;
  logic [IDX_W-1:0]  disp_tag_1, disp_tag_2;
  logic              full;
  logic              cmp_valid_0, cmp_valid_1, cmp_valid_2;
  logic [IDX_W-1:0]  cmp_tag_0, cmp_tag_1, cmp_tag_2;
  logic              ret_valid_1, ret_valid_2;
  logic [4:0]        ret_rd_1, ret_rd_2;
  logic [PREG_W-1:0] ret_prd_1, ret_prd_2;
  logic [PREG_W-1:0] ret_free_1, ret_free_2;
  logic              ret_free_valid_1, ret_free_valid_2;
  logic [IDX_W:0]    count;

  modport master (
    output disp_valid_1, disp_valid_2, disp_rd_1, disp_rd_2, disp_prd_1, disp_prd_2,
           disp_old_prd_1, disp_old_prd_2, disp_reg_write_1, disp_reg_write_2,
           cmp_valid_0, cmp_valid_1, cmp_valid_2, cmp_tag_0, cmp_tag_1, cmp_tag_2,
    input  disp_tag_1, disp_tag_2, full, ret_valid_1, ret_valid_2, ret_rd_1, ret_rd_2,
           ret_prd_1, ret_prd_2, ret_free_1, ret_free_2, ret_free_valid_1, ret_free_valid_2, count
  );

  modport slave (
    input  disp_valid_1, disp_valid_2, disp_rd_1, disp_rd_2, disp_prd_1, disp_prd_2,
           disp_old_prd_1, disp_old_prd_2, disp_reg_write_1, disp_reg_write_2,
           cmp_valid_0, cmp_valid_1, cmp_valid_2, cmp_tag_0, cmp_tag_1, cmp_tag_2,
    output disp_tag_1, disp_tag_2, full, ret_valid_1, ret_valid_2, ret_rd_1, ret_rd_2,
           ret_prd_1, ret_prd_2, ret_free_1, ret_free_2, ret_free_valid_1, ret_free_valid_2, count
  );
endinterface

// File: rtl/reorder_buffer.sv
// Dual-dispatch, in-order-retire ROB; define ROB_DUAL_RETIRE_EN to allow two retires per cycle.
// Tags are combinational from tail, retire strobes registered one edge after head is done; full (count >= DEPTH-1) refuses all dispatch.
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int PREG_W = 6,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input logic             clk,
  input logic             reset,
  reorder_buffer_if.slave rob
);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]  head, tail, count;
  logic [DEPTH-1:0]  valid, done, reg_write;
  logic [4:0]        rd_mem  [DEPTH];
  logic [PREG_W-1:0] prd_mem [DEPTH];
  logic [PREG_W-1:0] old_mem [DEPTH];
  logic [IDX_W-1:0]  head_idx, tail_idx, tag_1, tag_2;
  logic              full, acc_1, acc_2, ret_0, ret_1;
  logic              cmp_valid [3];
  logic [IDX_W-1:0]  cmp_tag   [3];

  assign head_idx = head[IDX_W-1:0];
  assign tail_idx = tail[IDX_W-1:0];
  assign count    = tail - head;
  // Refusing at DEPTH-1 keeps a dual dispatch all-or-nothing.
  assign full     = count >= PTR_W'(DEPTH - 1);
  assign tag_1    = tail_idx;
  assign tag_2    = rob.disp_valid_1 ? tail_idx + IDX_W'(1) : tail_idx;
  assign acc_1    = rob.disp_valid_1 && !full;
  assign acc_2    = rob.disp_valid_2 && !full;

  assign cmp_valid[0] = rob.cmp_valid_0;
  assign cmp_valid[1] = rob.cmp_valid_1;
  assign cmp_valid[2] = rob.cmp_valid_2;
  assign cmp_tag[0]   = rob.cmp_tag_0;
  assign cmp_tag[1]   = rob.cmp_tag_1;
  assign cmp_tag[2]   = rob.cmp_tag_2;

  assign ret_0 = valid[head_idx] && done[head_idx];
`ifdef ROB_DUAL_RETIRE_EN
  logic [IDX_W-1:0] head1_idx;
  assign head1_idx = head_idx + IDX_W'(1);
  assign ret_1     = ret_0 && valid[head1_idx] && done[head1_idx];
`else
  assign ret_1 = 1'b0;
`endif

  assign rob.disp_tag_1 = tag_1;
  assign rob.disp_tag_2 = tag_2;
  assign rob.full       = full;
  assign rob.count      = count;

  always_ff @(posedge clk) begin
    if (acc_1) begin
      rd_mem[tag_1]    <= rob.disp_rd_1;
      prd_mem[tag_1]   <= rob.disp_prd_1;
      old_mem[tag_1]   <= rob.disp_old_prd_1;
      reg_write[tag_1] <= rob.disp_reg_write_1;
    end
    if (acc_2) begin
      rd_mem[tag_2]    <= rob.disp_rd_2;
      prd_mem[tag_2]   <= rob.disp_prd_2;
      old_mem[tag_2]   <= rob.disp_old_prd_2;
      reg_write[tag_2] <= rob.disp_reg_write_2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head                 <= '0;
      tail                 <= '0;
      valid                <= '0;
      done                 <= '0;
      rob.ret_valid_1      <= 1'b0;
      rob.ret_rd_1         <= '0;
      rob.ret_prd_1        <= '0;
      rob.ret_free_1       <= '0;
      rob.ret_free_valid_1 <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++)
        if (cmp_valid[k] && valid[cmp_tag[k]]) done[cmp_tag[k]] <= 1'b1;
      if (ret_0) begin
        valid[head_idx] <= 1'b0;
        done[head_idx]  <= 1'b0;
      end
`ifdef ROB_DUAL_RETIRE_EN
      if (ret_1) begin
        valid[head1_idx] <= 1'b0;
        done[head1_idx]  <= 1'b0;
      end
`endif
      // Dispatch slots never alias a live entry, so these writes cannot collide with the above.
      if (acc_1) begin
        valid[tag_1] <= 1'b1;
        done[tag_1]  <= 1'b0;
      end
      if (acc_2) begin
        valid[tag_2] <= 1'b1;
        done[tag_2]  <= 1'b0;
      end
      head                 <= head + PTR_W'(ret_0) + PTR_W'(ret_1);
      tail                 <= tail + PTR_W'(acc_1) + PTR_W'(acc_2);
      rob.ret_valid_1      <= ret_0;
      rob.ret_rd_1         <= ret_0 ? rd_mem[head_idx] : '0;
      rob.ret_prd_1        <= ret_0 ? prd_mem[head_idx] : '0;
      rob.ret_free_1       <= ret_0 ? old_mem[head_idx] : '0;
      rob.ret_free_valid_1 <= ret_0 && reg_write[head_idx];
    end
  end

`ifdef ROB_DUAL_RETIRE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rob.ret_valid_2      <= 1'b0;
      rob.ret_rd_2         <= '0;
      rob.ret_prd_2        <= '0;
      rob.ret_free_2       <= '0;
      rob.ret_free_valid_2 <= 1'b0;
    end else begin
      rob.ret_valid_2      <= ret_1;
      rob.ret_rd_2         <= ret_1 ? rd_mem[head1_idx] : '0;
      rob.ret_prd_2        <= ret_1 ? prd_mem[head1_idx] : '0;
      rob.ret_free_2       <= ret_1 ? old_mem[head1_idx] : '0;
      rob.ret_free_valid_2 <= ret_1 && reg_write[head1_idx];
    end
  end
`else
  assign rob.ret_valid_2      = 1'b0;
  assign rob.ret_rd_2         = '0;
  assign rob.ret_prd_2        = '0;
  assign rob.ret_free_2       = '0;
  assign rob.ret_free_valid_2 = 1'b0;
`endif
endmodule

// File: tb/tb_reorder_buffer.sv
// Reorder buffer bench: directed scenarios plus randomized traffic against a queue-based program-order model.
module tb_reorder_buffer;
  localparam int DEPTH  = 16;
  localparam int PREG_W = 6;
  localparam int IDX_W  = 4;
`ifdef ROB_DUAL_RETIRE_EN
  localparam int RET_MAX = 2;
`else
  localparam int RET_MAX = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  reorder_buffer_if #(.DEPTH(DEPTH), .PREG_W(PREG_W), .IDX_W(IDX_W)) bus ();
  reorder_buffer #(.DEPTH(DEPTH), .PREG_W(PREG_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .rob(bus)
  );

  typedef struct packed {
    logic [3:0] tag;
    logic [4:0] rd;
    logic [5:0] prd;
    logic [5:0] old;
    logic       rw;
    logic       done;
  } ent_t;

  ent_t       q[$];
  int         next_tag;
  int         total = 0;
  int         bad = 0;
  logic       e_rv [2];
  logic [4:0] e_rd [2];
  logic [5:0] e_prd [2];
  logic [5:0] e_free [2];
  logic       e_fv [2];

  task automatic idle();
    bus.disp_valid_1 = 0; bus.disp_rd_1 = 0; bus.disp_prd_1 = 0; bus.disp_old_prd_1 = 0; bus.disp_reg_write_1 = 0;
    bus.disp_valid_2 = 0; bus.disp_rd_2 = 0; bus.disp_prd_2 = 0; bus.disp_old_prd_2 = 0; bus.disp_reg_write_2 = 0;
    bus.cmp_valid_0 = 0; bus.cmp_valid_1 = 0; bus.cmp_valid_2 = 0;
    bus.cmp_tag_0 = 0; bus.cmp_tag_1 = 0; bus.cmp_tag_2 = 0;
  endtask

  task automatic set_disp(input int slot, input int rd, input int prd, input int old, input bit rw);
    if (slot == 1) begin
      bus.disp_valid_1 = 1; bus.disp_rd_1 = 5'(rd); bus.disp_prd_1 = 6'(prd);
      bus.disp_old_prd_1 = 6'(old); bus.disp_reg_write_1 = rw;
    end else begin
      bus.disp_valid_2 = 1; bus.disp_rd_2 = 5'(rd); bus.disp_prd_2 = 6'(prd);
      bus.disp_old_prd_2 = 6'(old); bus.disp_reg_write_2 = rw;
    end
  endtask

  // One clock edge; the model retires from the oldest end of the queue, then completes, then appends.
  task automatic tick();
    int         nret;
    bit         acc;
    logic       cv [3];
    logic [3:0] ct [3];
    ent_t       e;
    for (int s = 0; s < 2; s++) begin
      e_rv[s] = 0; e_rd[s] = 0; e_prd[s] = 0; e_free[s] = 0; e_fv[s] = 0;
    end
    @(posedge clk);
    cv[0] = bus.cmp_valid_0; cv[1] = bus.cmp_valid_1; cv[2] = bus.cmp_valid_2;
    ct[0] = bus.cmp_tag_0;   ct[1] = bus.cmp_tag_1;   ct[2] = bus.cmp_tag_2;
    if (reset) begin
      q.delete();
      next_tag = 0;
    end else begin
      nret = 0;
      acc = q.size() < DEPTH - 1;
      while (nret < RET_MAX && nret < q.size() && q[nret].done) begin
        e_rv[nret] = 1; e_rd[nret] = q[nret].rd; e_prd[nret] = q[nret].prd;
        e_free[nret] = q[nret].old; e_fv[nret] = q[nret].rw;
        nret++;
      end
      repeat (nret) void'(q.pop_front());
      for (int k = 0; k < 3; k++)
        if (cv[k])
          for (int i = 0; i < q.size(); i++)
            if (q[i].tag == ct[k]) begin e = q[i]; e.done = 1; q[i] = e; end
      if (acc && bus.disp_valid_1) begin
        e = '{tag: 4'(next_tag), rd: bus.disp_rd_1, prd: bus.disp_prd_1, old: bus.disp_old_prd_1,
              rw: bus.disp_reg_write_1, done: 1'b0};
        q.push_back(e);
        next_tag = (next_tag + 1) % DEPTH;
      end
      if (acc && bus.disp_valid_2) begin
        e = '{tag: 4'(next_tag), rd: bus.disp_rd_2, prd: bus.disp_prd_2, old: bus.disp_old_prd_2,
              rw: bus.disp_reg_write_2, done: 1'b0};
        q.push_back(e);
        next_tag = (next_tag + 1) % DEPTH;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1; idle(); tick(); reset = 0;
  endtask

  task automatic test_reset();
    idle(); tick(); reset = 0; #1;
    total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.count); end
    total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b want=0", bus.full); end
    total++; if ({bus.ret_valid_1, bus.ret_valid_2, bus.ret_free_valid_1, bus.ret_free_valid_2} !== 4'b0) begin
      bad++; $display("FAIL reset_ret_valid got=%b want=0000",
                      {bus.ret_valid_1, bus.ret_valid_2, bus.ret_free_valid_1, bus.ret_free_valid_2});
    end
    total++; if ({bus.ret_rd_1, bus.ret_prd_1, bus.ret_free_1} !== 17'd0) begin
      bad++; $display("FAIL reset_ret_data got=%0h want=0", {bus.ret_rd_1, bus.ret_prd_1, bus.ret_free_1});
    end
    total++; if (bus.disp_tag_1 !== 4'd0) begin bad++; $display("FAIL reset_tag got=%0d want=0", bus.disp_tag_1); end
  endtask

  task automatic test_dual();
    do_reset();
    set_disp(1, 1, 33, 1, 1); set_disp(2, 2, 34, 2, 1); #1;
    total++; if ({bus.disp_tag_1, bus.disp_tag_2} !== {4'd0, 4'd1}) begin
      bad++; $display("FAIL dual_tags got=%0d/%0d want=0/1", bus.disp_tag_1, bus.disp_tag_2);
    end
    tick(); idle(); #1;
    total++; if (bus.count !== 5'd2) begin bad++; $display("FAIL dual_count got=%0d want=2", bus.count); end
    bus.cmp_valid_0 = 1; bus.cmp_tag_0 = 1; tick();
    bus.cmp_tag_0 = 0; tick(); idle();
    total++; if (bus.ret_valid_1 !== 1'b0) begin bad++; $display("FAIL dual_early got=%0b want=0", bus.ret_valid_1); end
    tick();
    total++; if ({bus.ret_valid_1, bus.ret_free_1, bus.ret_prd_1} !== {1'b1, 6'd1, 6'd33}) begin
      bad++; $display("FAIL dual_ret1 got=%0b/%0d/%0d want=1/1/33", bus.ret_valid_1, bus.ret_free_1, bus.ret_prd_1);
    end
`ifdef ROB_DUAL_RETIRE_EN
    total++; if ({bus.ret_valid_2, bus.ret_free_2, bus.count} !== {1'b1, 6'd2, 5'd0}) begin
      bad++; $display("FAIL dual_ret2 got=%0b/%0d cnt=%0d want=1/2 cnt=0", bus.ret_valid_2, bus.ret_free_2, bus.count);
    end
`else
    total++; if ({bus.ret_valid_2, bus.count} !== {1'b0, 5'd1}) begin
      bad++; $display("FAIL single_ret2 got=%0b cnt=%0d want=0 cnt=1", bus.ret_valid_2, bus.count);
    end
    tick();
    total++; if ({bus.ret_valid_1, bus.ret_free_1, bus.count} !== {1'b1, 6'd2, 5'd0}) begin
      bad++; $display("FAIL single_ret_next got=%0b/%0d cnt=%0d want=1/2 cnt=0", bus.ret_valid_1, bus.ret_free_1, bus.count);
    end
`endif
  endtask

  task automatic test_ooo();
    logic [4:0] seq[$];
    do_reset();
    set_disp(1, 3, 40, 10, 1); set_disp(2, 4, 41, 11, 1); tick(); idle();
    set_disp(1, 5, 42, 12, 1); tick(); idle();
    bus.cmp_valid_0 = 1; bus.cmp_tag_0 = 2; tick(); idle();
    for (int n = 0; n < 3; n++) begin
      tick();
      total++; if (bus.ret_valid_1 !== 1'b0) begin bad++; $display("FAIL ooo_early cyc=%0d got=%0b want=0", n, bus.ret_valid_1); end
    end
    bus.cmp_valid_0 = 1; bus.cmp_tag_0 = 0; bus.cmp_valid_1 = 1; bus.cmp_tag_1 = 1; tick(); idle();
    for (int n = 0; n < 5; n++) begin
      tick();
      if (bus.ret_valid_1) seq.push_back(bus.ret_rd_1);
      if (bus.ret_valid_2) seq.push_back(bus.ret_rd_2);
    end
    total++;
    if (seq.size() != 3) begin bad++; $display("FAIL ooo_len got=%0d want=3", seq.size()); end
    else for (int i = 0; i < 3; i++) begin
      total++; if (seq[i] !== 5'(3 + i)) begin bad++; $display("FAIL ooo_order idx=%0d got=%0d want=%0d", i, seq[i], 3 + i); end
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int n = 0; n < 7; n++) begin
      set_disp(1, n, n, n, 1); set_disp(2, n + 8, n + 8, n + 8, 1); tick(); idle();
    end
    total++; if ({bus.count, bus.full} !== {5'd14, 1'b0}) begin
      bad++; $display("FAIL full_14 got=%0d/%0b want=14/0", bus.count, bus.full);
    end
    set_disp(1, 20, 20, 20, 1); tick(); idle();
    total++; if ({bus.count, bus.full} !== {5'd15, 1'b1}) begin
      bad++; $display("FAIL full_15 got=%0d/%0b want=15/1", bus.count, bus.full);
    end
    set_disp(1, 21, 21, 21, 1); set_disp(2, 22, 22, 22, 1); #1;
    total++; if (bus.disp_tag_1 !== 4'd15) begin bad++; $display("FAIL full_tag got=%0d want=15", bus.disp_tag_1); end
    tick(); idle(); #1;
    total++; if ({bus.count, bus.disp_tag_1} !== {5'd15, 4'd15}) begin
      bad++; $display("FAIL full_pair_refused got=%0d tag=%0d want=15 tag=15", bus.count, bus.disp_tag_1);
    end
    set_disp(2, 23, 23, 23, 1); tick(); idle();
    total++; if (bus.count !== 5'd15) begin bad++; $display("FAIL full_single_refused got=%0d want=15", bus.count); end
  endtask

  task automatic test_wrap();
    logic [4:0] seq[$];
    do_reset();
    for (int i = 0; i < 20; i++) begin
      idle(); set_disp(1, i, 32 + i, i, 1);
      if (i > 0) begin bus.cmp_valid_0 = 1; bus.cmp_tag_0 = 4'((i - 1) % 16); end
      #1;
      total++; if (bus.disp_tag_1 !== 4'(i % 16)) begin bad++; $display("FAIL wrap_tag i=%0d got=%0d want=%0d", i, bus.disp_tag_1, i % 16); end
      tick();
      if (bus.ret_valid_1) seq.push_back(bus.ret_rd_1);
      if (bus.ret_valid_2) seq.push_back(bus.ret_rd_2);
    end
    idle(); bus.cmp_valid_0 = 1; bus.cmp_tag_0 = 4'd3;
    for (int n = 0; n < 4; n++) begin
      tick(); idle();
      if (bus.ret_valid_1) seq.push_back(bus.ret_rd_1);
      if (bus.ret_valid_2) seq.push_back(bus.ret_rd_2);
    end
    total++;
    if (seq.size() != 20) begin bad++; $display("FAIL wrap_len got=%0d want=20", seq.size()); end
    else for (int i = 0; i < 20; i++) begin
      total++; if (seq[i] !== 5'(i)) begin bad++; $display("FAIL wrap_order idx=%0d got=%0d want=%0d", i, seq[i], i); end
    end
    total++; if ({bus.count, bus.full} !== {5'd0, 1'b0}) begin bad++; $display("FAIL wrap_drain got=%0d/%0b want=0/0", bus.count, bus.full); end
  endtask

  task automatic test_store();
    do_reset();
    set_disp(1, 7, 50, 9, 0); tick(); idle();
    bus.cmp_valid_2 = 1; bus.cmp_tag_2 = 0; tick(); idle(); tick();
    total++; if ({bus.ret_valid_1, bus.ret_free_valid_1, bus.ret_rd_1, bus.ret_prd_1} !== {1'b1, 1'b0, 5'd7, 6'd50}) begin
      bad++; $display("FAIL store_ret got=%0b/%0b/%0d/%0d want=1/0/7/50",
                      bus.ret_valid_1, bus.ret_free_valid_1, bus.ret_rd_1, bus.ret_prd_1);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    set_disp(1, 1, 1, 1, 1); set_disp(2, 2, 2, 2, 1); tick(); idle();
    set_disp(1, 3, 3, 3, 1); set_disp(2, 4, 4, 4, 1); tick(); idle();
    set_disp(1, 5, 5, 5, 1); tick(); idle();
    bus.cmp_valid_0 = 1; bus.cmp_tag_0 = 0; bus.cmp_valid_1 = 1; bus.cmp_tag_1 = 1; tick();
    bus.cmp_tag_0 = 2; bus.cmp_tag_1 = 3; reset = 1; tick(); reset = 0; idle(); #1;
    total++; if ({bus.count, bus.full, bus.ret_valid_1, bus.ret_valid_2, bus.disp_tag_1} !== {5'd0, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      bad++; $display("FAIL midreset got cnt=%0d full=%0b rv=%0b%0b tag=%0d want 0/0/00/0",
                      bus.count, bus.full, bus.ret_valid_1, bus.ret_valid_2, bus.disp_tag_1);
    end
    tick();
    total++; if ({bus.ret_valid_1, bus.ret_free_valid_1, bus.count} !== {1'b0, 1'b0, 5'd0}) begin
      bad++; $display("FAIL midreset_after got rv=%0b fv=%0b cnt=%0d want 0/0/0", bus.ret_valid_1, bus.ret_free_valid_1, bus.count);
    end
  endtask

  task automatic pick_cmp(output logic v, output logic [3:0] t);
    v = ($urandom_range(0, 2) != 0);
    if (q.size() > 0 && $urandom_range(0, 4) != 0) t = q[$urandom_range(0, q.size() - 1)].tag;
    else t = 4'($urandom_range(0, 15));
  endtask

  task automatic test_random();
    logic       v;
    logic [3:0] t;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      idle();
      if ($urandom_range(0, 1) != 0)
        set_disp(1, $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) != 0)
        set_disp(2, $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63), 1'($urandom_range(0, 1)));
      pick_cmp(v, t); bus.cmp_valid_0 = v; bus.cmp_tag_0 = t;
      pick_cmp(v, t); bus.cmp_valid_1 = v; bus.cmp_tag_1 = t;
      pick_cmp(v, t); bus.cmp_valid_2 = v; bus.cmp_tag_2 = t;
      #1;
      total++; if ({bus.disp_tag_1, bus.disp_tag_2} !== {4'(next_tag), 4'(bus.disp_valid_1 ? next_tag + 1 : next_tag)}) begin
        bad++; $display("FAIL rnd_tags cyc=%0d got=%0d/%0d base=%0d", n, bus.disp_tag_1, bus.disp_tag_2, next_tag);
      end
      tick();
      total++; if ({bus.ret_valid_1, bus.ret_valid_2} !== {e_rv[0], e_rv[1]}) begin
        bad++; $display("FAIL rnd_ret_valid cyc=%0d got=%0b%0b want=%0b%0b", n, bus.ret_valid_1, bus.ret_valid_2, e_rv[0], e_rv[1]);
      end
      if (e_rv[0]) begin
        total++; if ({bus.ret_rd_1, bus.ret_prd_1, bus.ret_free_1, bus.ret_free_valid_1} !== {e_rd[0], e_prd[0], e_free[0], e_fv[0]}) begin
          bad++; $display("FAIL rnd_ret1 cyc=%0d got=%0d/%0d/%0d/%0b want=%0d/%0d/%0d/%0b", n, bus.ret_rd_1, bus.ret_prd_1,
                          bus.ret_free_1, bus.ret_free_valid_1, e_rd[0], e_prd[0], e_free[0], e_fv[0]);
        end
      end
      if (e_rv[1]) begin
        total++; if ({bus.ret_rd_2, bus.ret_prd_2, bus.ret_free_2, bus.ret_free_valid_2} !== {e_rd[1], e_prd[1], e_free[1], e_fv[1]}) begin
          bad++; $display("FAIL rnd_ret2 cyc=%0d got=%0d/%0d/%0d/%0b want=%0d/%0d/%0d/%0b", n, bus.ret_rd_2, bus.ret_prd_2,
                          bus.ret_free_2, bus.ret_free_valid_2, e_rd[1], e_prd[1], e_free[1], e_fv[1]);
        end
      end
      total++; if ({bus.count, bus.full} !== {5'(q.size()), (q.size() >= DEPTH - 1)}) begin
        bad++; $display("FAIL rnd_count cyc=%0d got=%0d/%0b want=%0d/%0b", n, bus.count, bus.full, q.size(), q.size() >= DEPTH - 1);
      end
    end
  endtask

  initial begin
    next_tag = 0;
    test_reset();
    test_dual();
    test_ooo();
    test_full();
    test_wrap();
    test_store();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
